// File: rtl/cpsr_unit_pkg.sv
// Shared types and constants for the CPSR status block.
// Flag bit layout is {N,Z,C,V} in a 4-bit vector.
package cpsr_unit_pkg;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam int CNT_W_DEF = 8;

  typedef logic [3:0] flags_t;

  function automatic flags_t pack_flags(
    input logic n,
    input logic z,
    input logic c,
    input logic v
  );
    flags_t f;
    f         = '0;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/cpsr_unit_ovf_counter.sv
// Sticky overflow bit plus a wrapping overflow-event counter.
// A clear on the same edge as an increment wins and leaves zero.
module ovf_counter
  import cpsr_unit_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic             sticky_o,
  output logic [CNT_W-1:0] count_o
);

  logic             sticky_q;
  logic             sticky_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next state: clear beats increment; counter wraps naturally.
  always_comb begin
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    if (clr_i) begin
      sticky_d = 1'b0;
      cnt_d    = '0;
    end else if (inc_i) begin
      sticky_d = 1'b1;
      cnt_d    = cnt_q + 1'b1;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  assign sticky_o = sticky_q;
  assign count_o  = cnt_q;

endmodule

// File: rtl/cpsr_unit.sv
// N/Z/C/V flag register, flag-conditioned branch resolve and
// overflow debug tracking between ALU, decoder and PC select.
module cpsr_unit
  import cpsr_unit_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int BYPASS = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  input  logic             cpsr_update,
  input  logic             cpsr_reset,
  input  logic             bvf,
  input  logic             ben,
  input  logic             alu_n,
  input  logic             alu_z,
  input  logic             alu_c,
  input  logic             alu_v,
  input  logic             sticky_clr,
  output logic [3:0]       flags,
  output logic             branch_taken,
  output logic             flush,
  output logic             ovf_sticky,
  output logic [CNT_W-1:0] ovf_count
);

  flags_t flags_q;
  flags_t flags_d;
  flags_t alu_f;
  flags_t cond_f;
  logic   take_q;
  logic   take_d;
  logic   load;
  logic   ovf_inc;

  assign alu_f = pack_flags(alu_n, alu_z, alu_c, alu_v);
  assign load  = cpsr_update & ~cpsr_reset;

  // Flag write: clear beats load, bubbles hold.
  always_comb begin
    flags_d = flags_q;
    if (instr_valid) begin
      if (cpsr_reset) begin
        flags_d = '0;
      end else if (cpsr_update) begin
        flags_d = alu_f;
      end
    end
  end

  // Branch resolve on pre-write flags, optionally forwarding ALU flags.
  always_comb begin
    cond_f = flags_q;
    if ((BYPASS != 0) && load) begin
      cond_f = alu_f;
    end
    take_d = instr_valid &
             ((bvf & cond_f[FLAG_V]) |
              (ben & cond_f[FLAG_N]));
  end

  // Flag and branch-pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= '0;
      take_q  <= 1'b0;
    end else begin
      flags_q <= flags_d;
      take_q  <= take_d;
    end
  end

  assign ovf_inc = instr_valid & load & alu_v;

  ovf_counter #(
    .CNT_W (CNT_W)
  ) u_ovf (
    .clk      (clk),
    .rst      (rst),
    .inc_i    (ovf_inc),
    .clr_i    (sticky_clr),
    .sticky_o (ovf_sticky),
    .count_o  (ovf_count)
  );

  assign flags        = flags_q;
  assign branch_taken = take_q;
  assign flush        = take_q;

endmodule

// File: tb/tb_cpsr_unit.sv
// Scoreboard bench for cpsr_unit: three instances share stimulus
// (default, BYPASS=1, CNT_W=2) and a monitor checks each cycle.
module tb_cpsr_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic iv, upd, crs, bvf, ben, an, az, ac, av, clr;

  logic [3:0] fa, fb, fc;
  logic       bta, btb, btc, fla, flb, flc;
  logic       sa, sb, sc;
  logic [7:0] ca, cb;
  logic [1:0] cc;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] f;
    logic       bta;
    logic       btb;
    logic       s;
    logic [7:0] ca;
    logic [1:0] cc;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  cpsr_unit #(.CNT_W(8), .BYPASS(0)) u_a (
    .clk(clk), .rst(rst), .instr_valid(iv),
    .cpsr_update(upd), .cpsr_reset(crs),
    .bvf(bvf), .ben(ben),
    .alu_n(an), .alu_z(az), .alu_c(ac), .alu_v(av),
    .sticky_clr(clr), .flags(fa),
    .branch_taken(bta), .flush(fla),
    .ovf_sticky(sa), .ovf_count(ca));

  cpsr_unit #(.CNT_W(8), .BYPASS(1)) u_b (
    .clk(clk), .rst(rst), .instr_valid(iv),
    .cpsr_update(upd), .cpsr_reset(crs),
    .bvf(bvf), .ben(ben),
    .alu_n(an), .alu_z(az), .alu_c(ac), .alu_v(av),
    .sticky_clr(clr), .flags(fb),
    .branch_taken(btb), .flush(flb),
    .ovf_sticky(sb), .ovf_count(cb));

  cpsr_unit #(.CNT_W(2), .BYPASS(0)) u_c (
    .clk(clk), .rst(rst), .instr_valid(iv),
    .cpsr_update(upd), .cpsr_reset(crs),
    .bvf(bvf), .ben(ben),
    .alu_n(an), .alu_z(az), .alu_c(ac), .alu_v(av),
    .sticky_clr(clr), .flags(fc),
    .branch_taken(btc), .flush(flc),
    .ovf_sticky(sc), .ovf_count(cc));

  task automatic chk(input string nm, input int act,
                     input int exp, input int idx);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s step=%0d got=%0h want=%0h",
               nm, idx, act, exp);
    end
  endtask

  // Monitor: one expected entry per clock, checked after the edge.
  initial begin : mon
    int n;
    exp_t e;
    n = 0;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        n++;
        chk("flags_a", fa, e.f, n);
        chk("flags_b", fb, e.f, n);
        chk("flags_c", fc, e.f, n);
        chk("bt_a", bta, e.bta, n);
        chk("flush_a", fla, e.bta, n);
        chk("bt_b", btb, e.btb, n);
        chk("flush_b", flb, e.btb, n);
        chk("bt_c", btc, e.bta, n);
        chk("sticky_a", sa, e.s, n);
        chk("sticky_c", sc, e.s, n);
        chk("cnt_a", ca, e.ca, n);
        chk("cnt_b", cb, e.ca, n);
        chk("cnt_c", cc, e.cc, n);
      end
    end
  end

  task automatic vec(
    input logic v_iv, input logic v_upd, input logic v_crs,
    input logic v_bvf, input logic v_ben, input logic [3:0] v_alu,
    input logic v_clr, input logic [3:0] e_f, input logic e_bta,
    input logic e_btb, input logic e_s, input logic [7:0] e_ca,
    input logic [1:0] e_cc);
    exp_t e;
    @(negedge clk);
    iv  = v_iv;  upd = v_upd; crs = v_crs;
    bvf = v_bvf; ben = v_ben; clr = v_clr;
    {an, az, ac, av} = v_alu;
    e.f = e_f; e.bta = e_bta; e.btb = e_btb;
    e.s = e_s; e.ca = e_ca; e.cc = e_cc;
    q.push_back(e);
  endtask

  initial begin : drv
    {iv, upd, crs, bvf, ben, an, az, ac, av, clr} = '0;
    #2;
    chk("rst_flags", fa, 0, 0);
    chk("rst_bt", bta, 0, 0);
    chk("rst_cnt", ca, 0, 0);
    chk("rst_sticky", sa, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    //   iv upd crs bvf ben alu     clr  F       bA bB s cA cC
    vec(1, 1, 0, 0, 0, 4'b0001, 0, 4'b0001, 0, 0, 1, 1, 1);
    vec(1, 0, 1, 1, 0, 4'b0000, 0, 4'b0000, 1, 1, 1, 1, 1);
    vec(1, 0, 1, 1, 0, 4'b0000, 0, 4'b0000, 0, 0, 1, 1, 1);
    vec(1, 0, 1, 0, 1, 4'b0000, 0, 4'b0000, 0, 0, 1, 1, 1);
    vec(1, 1, 0, 0, 1, 4'b1000, 0, 4'b1000, 0, 1, 1, 1, 1);
    vec(1, 0, 1, 0, 1, 4'b0000, 0, 4'b0000, 1, 1, 1, 1, 1);
    vec(0, 1, 0, 1, 0, 4'b0001, 0, 4'b0000, 0, 0, 1, 1, 1);
    vec(1, 1, 0, 0, 0, 4'b0101, 0, 4'b0101, 0, 0, 1, 2, 2);
    vec(1, 1, 0, 0, 0, 4'b0011, 0, 4'b0011, 0, 0, 1, 3, 3);
    vec(1, 1, 0, 0, 0, 4'b1001, 0, 4'b1001, 0, 0, 1, 4, 0);
    vec(1, 1, 0, 0, 0, 4'b0001, 1, 4'b0001, 0, 0, 0, 0, 0);
    vec(1, 1, 1, 0, 0, 4'b1111, 0, 4'b0000, 0, 0, 0, 0, 0);
    vec(1, 1, 0, 0, 0, 4'b0001, 0, 4'b0001, 0, 0, 1, 1, 1);
    vec(0, 0, 0, 0, 0, 4'b0000, 1, 4'b0001, 0, 0, 0, 0, 0);
    vec(1, 0, 0, 1, 1, 4'b0000, 0, 4'b0001, 1, 1, 0, 0, 0);
    vec(1, 1, 0, 1, 0, 4'b0000, 0, 4'b0000, 1, 0, 0, 0, 0);
    vec(1, 0, 0, 0, 0, 4'b0000, 0, 4'b0000, 0, 0, 0, 0, 0);
    vec(1, 1, 0, 0, 0, 4'b0001, 0, 4'b0001, 0, 0, 1, 1, 1);
    vec(1, 1, 0, 0, 0, 4'b0001, 0, 4'b0001, 0, 0, 1, 2, 2);
    vec(1, 1, 0, 0, 0, 4'b0001, 0, 4'b0001, 0, 0, 1, 3, 3);
    vec(1, 1, 0, 0, 0, 4'b0001, 0, 4'b0001, 0, 0, 1, 4, 0);
    vec(1, 1, 0, 0, 0, 4'b1011, 0, 4'b1011, 0, 0, 1, 5, 1);
    vec(1, 0, 0, 1, 0, 4'b0000, 0, 4'b1011, 1, 1, 1, 5, 1);
    @(negedge clk);
    {iv, upd, crs, bvf, ben, an, az, ac, av, clr} = '0;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_flags", fa, 0, 99);
    chk("arst_bt", bta, 0, 99);
    chk("arst_flush", fla, 0, 99);
    chk("arst_cnt", ca, 0, 99);
    chk("arst_sticky", sa, 0, 99);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("q_drained", q.size(), 0, 100);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard bound on run time.
  initial begin : wd
    #20000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule

// File: doc/cpsr_unit.md
Name: cpsr_unit

Overview:
- Status-register block that consumes the main decoder's flag-control outputs (cpsr_update, cpsr_reset, bvf, ben) together with the ALU flag outputs.
- Holds the architectural N/Z/C/V flags and resolves the flag-conditioned branches (bvf: branch if V; ben: branch if N).
- Keeps a sticky overflow bit and a wrapping overflow-event counter for debug.
- Sits between the ALU, the main decoder and the PC-select logic.

Parameters:
- CNT_W, 8, width of the overflow-event counter.
- BYPASS, 0, 1 = branch resolution sees this cycle's ALU flags when they are being written; 0 = branch sees registered flags only.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- instr_valid  input  1  current decoder outputs belong to a retiring instruction; 0 = bubble/stall, no state change.
- cpsr_update  input  1  load flags from ALU.
- cpsr_reset  input  1  clear N/Z/C/V.
- bvf  input  1  branch-on-overflow instruction.
- ben  input  1  branch-on-negative instruction.
- alu_n, alu_z, alu_c, alu_v  input  1 each  ALU result flags this cycle.
- sticky_clr  input  1  clear sticky overflow bit and counter.
- flags  output  4  registered {N,Z,C,V}.
- branch_taken  output  1  registered, one-cycle pulse: flag branch taken.
- flush  output  1  registered, equals branch_taken; squashes the younger fetched instruction.
- ovf_sticky  output  1  set by any committed V=1 update.
- ovf_count  output  CNT_W  count of committed V=1 updates.

Behaviour:
- Reset (async, rst=1): flags=4'b0000, branch_taken=0, flush=0, ovf_sticky=0, ovf_count=0. All take effect immediately, independent of clk.
- All state changes happen on the rising clk edge and only when instr_valid=1. With instr_valid=0, all registers hold, and branch_taken/flush are 0 on the next edge.
- Flag write priority, per edge with instr_valid=1:
  - cpsr_reset=1: flags <= 0. Reset beats update if both are asserted, which is illegal but defined.
  - else cpsr_update=1: flags <= {alu_n,alu_z,alu_c,alu_v}.
  - else: hold.
- Branch resolution:
  - cond_v = V, cond_n = N of the flag value before this edge's write.
  - Exception: if BYPASS=1 and cpsr_update=1 and cpsr_reset=0 in the same cycle, use the alu_* flags instead.
  - take = instr_valid & ((bvf & cond_v) | (ben & cond_n)).
  - branch_taken <= take; flush <= take. Latency is one cycle from the branch instruction's cycle to the pulse.
  - The decoder asserts cpsr_reset for bvf/ben themselves. Evaluation therefore must use pre-clear flags: a bvf with V=1 is taken, and flags are 0 afterwards.
  - bvf and ben both asserted (illegal): take = cond_v | cond_n.
- Overflow tracking, on an edge with instr_valid=1, cpsr_update=1, cpsr_reset=0, alu_v=1:
  - ovf_sticky <= 1.
  - ovf_count <= ovf_count+1. The counter wraps modulo 2^CNT_W with no saturation; all-ones +1 gives 0.
- sticky_clr:
  - Acts regardless of instr_valid.
  - Clears ovf_sticky and ovf_count on the edge.
  - Beats a simultaneous increment: the result is 0, not 1.
- Back-to-back branches:
  - Each is evaluated independently on its own cycle's flags.
  - A second bvf right after a taken bvf sees cleared flags and is not taken.
- Reset asserted mid-branch suppresses any pending branch_taken pulse immediately.

Decomposition:
- Shared package: flag bit indices (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0), a 4-bit flags typedef, and the CNT_W default.
- One natural sub-module, ovf_counter: sticky bit plus wrapping counter with clear-over-increment priority.
- Flag register and branch resolve stay in cpsr_unit.

Test Plan:
- Reset: rst=1 mid-cycle with flags=4'b1011, ovf_count=5 -> flags=0, ovf_count=0, branch_taken=0 immediately, without a clock edge.
- Update then branch: cycle0 cpsr_update, alu_v=1, alu_n=0; cycle1 bvf+cpsr_reset -> branch_taken=1 and flush=1 in cycle2, flags=0 in cycle2, ovf_count=1, ovf_sticky=1.
- Not taken plus bypass:
  - cycle0 cpsr_reset; cycle1 ben with N=0 -> no pulse.
  - Repeat with BYPASS=1 and a cycle that has cpsr_update, alu_n=1 and ben together -> taken. With BYPASS=0 the same cycle is not taken.
- Stall: instr_valid=0 with cpsr_update=1, alu_v=1, bvf=1 -> flags unchanged, ovf_count unchanged, branch_taken=0.
- Counter wrap/clear:
  - CNT_W=2, four V updates -> ovf_count 1,2,3,0; ovf_sticky stays 1.
  - sticky_clr coincident with a V update -> ovf_count=0, ovf_sticky=0.
- Priority: cpsr_reset and cpsr_update both 1 with alu flags 4'b1111 -> flags=0, ovf_count not incremented.
